// File: rtl/sdfa_pkg.sv
// Shared constants and state type for the sdfa adder arbiter slice.
// Saturation limits are derived from the operand width so any CAL_BIT works.
package sdfa_pkg;

  localparam int SDFA_CAL_BIT = 10;

  function automatic logic [31:0] sdfa_cal_max(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sdfa_cal_min(input int width);
    return 32'd1 << (width - 1);
  endfunction

  localparam logic [SDFA_CAL_BIT-1:0] SDFA_CAL_MAX = SDFA_CAL_BIT'(sdfa_cal_max(SDFA_CAL_BIT));
  localparam logic [SDFA_CAL_BIT-1:0] SDFA_CAL_MIN = SDFA_CAL_BIT'(sdfa_cal_min(SDFA_CAL_BIT));

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sdfa_state_e;

endpackage

// File: rtl/sdfa_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module sdfa_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_BIT  = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BIT-1:0]  ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_BIT-1:0]  idx,
  output logic               any
);

  int pos;

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = ID_BIT'(pos);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdfa_adder_arbiter.sv
// Round-robin shared saturating adder with a single registered result port.
// Optional saturation event counter enabled by defining SDFA_ARB_SAT_CNT_EN.
module sdfa_adder_arbiter
  import sdfa_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REQ_ID_BIT = 2,
  parameter int CAL_BIT    = SDFA_CAL_BIT
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  output logic [NUM_REQ-1:0]         REQ_READY,
  input  logic [NUM_REQ*CAL_BIT-1:0] REQ_IN1,
  input  logic [NUM_REQ*CAL_BIT-1:0] REQ_IN2,
  output logic                       RES_VALID,
  input  logic                       RES_READY,
  output logic [CAL_BIT-1:0]         RES_DATA,
  output logic [REQ_ID_BIT-1:0]      RES_ID,
  output logic                       RES_SAT
`ifdef SDFA_ARB_SAT_CNT_EN
  ,
  output logic [15:0]                SAT_CNT,
  input  logic                       CNT_CLR
`endif
);

  localparam logic [CAL_BIT-1:0] CAL_MAX = CAL_BIT'(sdfa_cal_max(CAL_BIT));
  localparam logic [CAL_BIT-1:0] CAL_MIN = CAL_BIT'(sdfa_cal_min(CAL_BIT));

  sdfa_state_e             state_q, state_d;
  logic [REQ_ID_BIT-1:0]   ptr_q, ptr_d;
  logic [CAL_BIT-1:0]      data_q, data_d;
  logic [REQ_ID_BIT-1:0]   id_q, id_d;
  logic                    sat_q, sat_d;

  logic                    accept;
  logic                    grant;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [REQ_ID_BIT-1:0]   pick_idx;
  logic                    pick_any;
  logic [CAL_BIT-1:0]      op_a, op_b, sum_raw, sum_sat;
  logic                    pos_ovf, neg_ovf;

  sdfa_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BIT  (REQ_ID_BIT)
  ) u_pick (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Ready is masked during reset so no requester believes it was accepted.
  always_comb begin
    accept    = (state_q == ST_EMPTY) | RES_READY;
    grant     = RSTN & accept & pick_any;
    REQ_READY = grant ? pick_gnt : '0;
  end

  always_comb begin
    op_a    = REQ_IN1[pick_idx*CAL_BIT +: CAL_BIT];
    op_b    = REQ_IN2[pick_idx*CAL_BIT +: CAL_BIT];
    sum_raw = op_a + op_b;
    pos_ovf = ~op_a[CAL_BIT-1] & ~op_b[CAL_BIT-1] &  sum_raw[CAL_BIT-1];
    neg_ovf =  op_a[CAL_BIT-1] &  op_b[CAL_BIT-1] & ~sum_raw[CAL_BIT-1];
    sum_sat = pos_ovf ? CAL_MAX : (neg_ovf ? CAL_MIN : sum_raw);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    sat_d   = sat_q;
    if (grant) begin
      state_d = ST_FULL;
      ptr_d   = (pick_idx == REQ_ID_BIT'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      data_d  = sum_sat;
      id_d    = pick_idx;
      sat_d   = pos_ovf | neg_ovf;
    end else if (RES_READY) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
    end
  end

  assign RES_VALID = (state_q == ST_FULL);
  assign RES_DATA  = data_q;
  assign RES_ID    = id_q;
  assign RES_SAT   = sat_q;

`ifdef SDFA_ARB_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (CNT_CLR) begin
      sat_cnt_d = '0;
    end else if (grant && (pos_ovf | neg_ovf) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign SAT_CNT = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sdfa_adder_arbiter.sv
// Scoreboard bench for sdfa_adder_arbiter: reference model predicts grants and sums,
// a separate monitor compares every presented result against the expected queue.
module tb_sdfa_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_BIT  = 2;
  localparam int CAL     = 10;
  localparam int VMAX    = (1 << (CAL - 1)) - 1;
  localparam int VMIN    = -(1 << (CAL - 1));

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*CAL-1:0] req_in1, req_in2;
  logic                   res_valid, res_ready;
  logic [CAL-1:0]         res_data;
  logic [ID_BIT-1:0]      res_id;
  logic                   res_sat;
  logic [15:0]            sat_cnt;
  logic                   cnt_clr;

  typedef struct {
    int id;
    int data;
    int sat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   m_ptr  = 0;
  bit   m_full = 1'b0;
  int   m_cnt  = 0;

  always #5 clk = ~clk;

  sdfa_adder_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .REQ_ID_BIT (ID_BIT),
    .CAL_BIT    (CAL)
  ) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_IN1   (req_in1),
    .REQ_IN2   (req_in2),
    .RES_VALID (res_valid),
    .RES_READY (res_ready),
    .RES_DATA  (res_data),
    .RES_ID    (res_id),
    .RES_SAT   (res_sat)
`ifdef SDFA_ARB_SAT_CNT_EN
    ,
    .SAT_CNT   (sat_cnt),
    .CNT_CLR   (cnt_clr)
`endif
  );

`ifndef SDFA_ARB_SAT_CNT_EN
  assign sat_cnt = '0;
`endif

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_in1[i*CAL +: CAL] = CAL'(a);
    req_in2[i*CAL +: CAL] = CAL'(b);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_in1[i*CAL +: CAL] = CAL'($urandom_range(0, (1 << CAL) - 1));
      req_in2[i*CAL +: CAL] = CAL'($urandom_range(0, (1 << CAL) - 1));
    end
  endtask

  // Reference model: arbitration and saturating arithmetic from plain integer rules.
  always @(negedge clk) begin
    if (!rstn) begin
      check("ready_in_reset", int'(req_ready), 0);
      check("valid_in_reset", int'(res_valid), 0);
      m_ptr  = 0;
      m_full = 1'b0;
      m_cnt  = 0;
      sb_q.delete();
    end else begin
      int winner;
      int exp_ready;
      int a, b, s;
      bit clamp;
      winner    = -1;
      exp_ready = 0;
      clamp     = 1'b0;
      if (!m_full || res_ready) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (winner < 0 && req_valid[(m_ptr + k) % NUM_REQ]) winner = (m_ptr + k) % NUM_REQ;
        end
      end
      if (winner >= 0) exp_ready = 1 << winner;
      check("req_ready", int'(req_ready), exp_ready);
      check("res_valid", int'(res_valid), int'(m_full));
`ifdef SDFA_ARB_SAT_CNT_EN
      check("sat_cnt", int'(sat_cnt), m_cnt);
`endif
      if (winner >= 0) begin
        a = int'($signed(req_in1[winner*CAL +: CAL]));
        b = int'($signed(req_in2[winner*CAL +: CAL]));
        s = a + b;
        if (s > VMAX) begin s = VMAX; clamp = 1'b1; end
        if (s < VMIN) begin s = VMIN; clamp = 1'b1; end
        sb_q.push_back('{id: winner, data: s, sat: int'(clamp)});
        m_ptr = (winner + 1) % NUM_REQ;
      end
      if (cnt_clr) m_cnt = 0;
      else if (clamp && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_full = (winner >= 0) || (m_full && !res_ready);
    end
  end

  // Monitor: compares whatever the result port presents against the queue head.
  always @(negedge clk) begin
    if (rstn && res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("res_data", int'($signed(res_data)), sb_q[0].data);
        check("res_id", int'(res_id), sb_q[0].id);
        check("res_sat", int'(res_sat), sb_q[0].sat);
        if (res_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    res_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (3) step();
    rstn = 1'b1;

    // Single plain add from requester 0.
    set_op(0, 100, -50);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    step();
    req_valid = '0;
    check("tp_add_data", int'($signed(res_data)), 50);
    check("tp_add_id", int'(res_id), 0);
    step();

    // Positive then negative clamp from requester 2.
    set_op(2, 300, 300);
    req_valid = 4'b0100;
    step();
    check("tp_pos_sat", int'(res_data), 'h1FF);
    set_op(2, -300, -300);
    step();
    check("tp_neg_sat", int'(res_data), 'h200);
    req_valid = '0;
    step();
`ifdef SDFA_ARB_SAT_CNT_EN
    check("tp_sat_cnt_two", int'(sat_cnt), 2);
`endif
    step();

    // All requesting from reset: strict rotation with no bubbles.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    randomize_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_id", int'(res_id), k % NUM_REQ);
      check("rr_valid", int'(res_valid), 1);
    end

    // Back-pressure while full, then release.
    res_ready = 1'b0;
    repeat (3) step();
    res_ready = 1'b1;
    step();
    check("release_id", int'(res_id), 0);

    // Reset while full drops the result at once; rotation restarts at 0.
    req_valid = 4'b1111;
    rstn = 1'b0;
    #1;
    check("async_drop", int'(res_valid), 0);
    step();
    rstn = 1'b1;
    step();
    check("post_reset_id", int'(res_id), 0);

    // Randomized traffic and back-pressure.
    for (int n = 0; n < 400; n++) begin
      randomize_ops();
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      res_ready = ($urandom_range(0, 3) != 0);
`ifdef SDFA_ARB_SAT_CNT_EN
      cnt_clr = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    cnt_clr = 1'b0;

`ifdef SDFA_ARB_SAT_CNT_EN
    // Drive the counter into its ceiling, then clear against a saturating grant.
    res_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 300, 300);
    repeat (65540) step();
    check("cnt_ceiling", int'(sat_cnt), 'hFFFF);
    step();
    check("cnt_hold", int'(sat_cnt), 'hFFFF);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_clr_priority", int'(sat_cnt), 0);
`endif

    // Drain: every predicted result must have been presented.
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
